// File: rtl/pipe_decoder.sv
// Registered MIPS instruction-decode stage with a 2-entry skid buffer.
// Fields, extended immediate and branch/jump targets are computed on entry and held in M/S.
module pipe_decoder #(
    parameter int PC_WIDTH   = 32,
    parameter bit ZEXT_LOGIC = 1'b1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_inst,
    input  logic [PC_WIDTH-1:0]  in_pc,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [5:0]           out_opcode,
    output logic [4:0]           out_rs,
    output logic [4:0]           out_rt,
    output logic [4:0]           out_rd,
    output logic [4:0]           out_shamt,
    output logic [5:0]           out_funct,
    output logic [15:0]          out_imm16,
    output logic [25:0]          out_imm26,
    output logic [31:0]          out_imm_ext,
    output logic [PC_WIDTH-1:0]  out_pc,
    output logic [PC_WIDTH-1:0]  out_br_target,
    output logic [PC_WIDTH-1:0]  out_j_target,
    output logic [CNT_WIDTH-1:0] dec_count
);

    typedef struct packed {
        logic [31:0]         inst;
        logic [PC_WIDTH-1:0] pc;
        logic [31:0]         imm_ext;
        logic [PC_WIDTH-1:0] br_target;
        logic [PC_WIDTH-1:0] j_target;
    } entry_t;

    entry_t               m, s, dec;
    logic                 m_valid, s_valid;
    logic [CNT_WIDTH-1:0] count;
    logic                 accept, fire, is_logical;
    logic [15:0]          imm;
    logic [31:0]          sext;
    logic [PC_WIDTH-1:0]  pc4;

    always_comb begin
        imm        = in_inst[15:0];
        sext       = {{16{imm[15]}}, imm};
        is_logical = in_inst[31:26] inside {6'h0C, 6'h0D, 6'h0E};
        pc4        = in_pc + PC_WIDTH'(4);

        dec.inst      = in_inst;
        dec.pc        = in_pc;
        dec.imm_ext   = (ZEXT_LOGIC && is_logical) ? {16'h0000, imm} : sext;
        dec.br_target = pc4 + PC_WIDTH'({sext[29:0], 2'b00});
        // Jump keeps the region bits of pc+4; the mask is all-ones below bit 28.
        dec.j_target  = (pc4 & ~PC_WIDTH'(32'h0FFF_FFFF)) | PC_WIDTH'({in_inst[25:0], 2'b00});
    end

    // in_ready comes only from the skid flag (and reset), never from out_ready.
    assign in_ready  = !s_valid && !rst;
    assign out_valid = m_valid;
    assign accept    = in_valid && in_ready;
    assign fire      = m_valid && out_ready;

    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register sees pre-edge values.
        if (rst) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
            // NOTE: data registers are reset too, because outputs must read zero after reset.
            m       <= '0;
            s       <= '0;
            count   <= '0;
        end else if (flush) begin
            m_valid <= 1'b0;
            s_valid <= 1'b0;
        end else begin
            if (fire)
                count <= count + CNT_WIDTH'(1);
            if (!s_valid) begin
                if (accept && (!m_valid || fire)) begin
                    m       <= dec;
                    m_valid <= 1'b1;
                end else if (accept) begin
                    s       <= dec;
                    s_valid <= 1'b1;
                end else if (fire) begin
                    m_valid <= 1'b0;
                end
            end else if (fire) begin
                m       <= s;
                s_valid <= 1'b0;
            end
        end
    end

    assign out_opcode    = m.inst[31:26];
    assign out_rs        = m.inst[25:21];
    assign out_rt        = m.inst[20:16];
    assign out_rd        = m.inst[15:11];
    assign out_shamt     = m.inst[10:6];
    assign out_funct     = m.inst[5:0];
    assign out_imm16     = m.inst[15:0];
    assign out_imm26     = m.inst[25:0];
    assign out_imm_ext   = m.imm_ext;
    assign out_pc        = m.pc;
    assign out_br_target = m.br_target;
    assign out_j_target  = m.j_target;
    assign dec_count     = count;

endmodule

// File: tb/tb_pipe_decoder.sv
// Scoreboard bench for pipe_decoder: a queue model of the buffered entries is checked
// every negedge against two DUTs (logical zero-extend on and off).
module tb_pipe_decoder;

    localparam int PW = 32;
    localparam int CW = 4;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
        logic [31:0] imm_zx;
        logic [31:0] imm_sx;
        logic [31:0] br;
        logic [31:0] jt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic          flush = 1'b0;
    logic          out_ready = 1'b0;
    logic [31:0]   in_inst = '0;
    logic [PW-1:0] in_pc = '0;

    logic          in_ready, out_valid;
    logic [5:0]    out_opcode, out_funct;
    logic [4:0]    out_rs, out_rt, out_rd, out_shamt;
    logic [15:0]   out_imm16;
    logic [25:0]   out_imm26;
    logic [31:0]   out_imm_ext;
    logic [PW-1:0] out_pc, out_br_target, out_j_target;
    logic [CW-1:0] dec_count;

    logic          s_in_ready, s_out_valid;
    logic [5:0]    s_opcode, s_funct;
    logic [4:0]    s_rs, s_rt, s_rd, s_shamt;
    logic [15:0]   s_imm16;
    logic [25:0]   s_imm26;
    logic [31:0]   s_imm_ext;
    logic [PW-1:0] s_pc, s_br_target, s_j_target;
    logic [CW-1:0] s_dec_count;

    int n_checks = 0;
    int n_fail   = 0;

    exp_t          q[$];
    logic [CW-1:0] exp_cnt  = '0;
    bit            exp_zero = 1'b1;

    always #5 clk = ~clk;

    pipe_decoder #(.PC_WIDTH(PW), .ZEXT_LOGIC(1'b1), .CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_opcode(out_opcode), .out_rs(out_rs), .out_rt(out_rt), .out_rd(out_rd),
        .out_shamt(out_shamt), .out_funct(out_funct), .out_imm16(out_imm16),
        .out_imm26(out_imm26), .out_imm_ext(out_imm_ext), .out_pc(out_pc),
        .out_br_target(out_br_target), .out_j_target(out_j_target), .dec_count(dec_count)
    );

    pipe_decoder #(.PC_WIDTH(PW), .ZEXT_LOGIC(1'b0), .CNT_WIDTH(CW)) u_sext (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .flush(flush),
        .out_valid(s_out_valid), .out_ready(out_ready),
        .out_opcode(s_opcode), .out_rs(s_rs), .out_rt(s_rt), .out_rd(s_rd),
        .out_shamt(s_shamt), .out_funct(s_funct), .out_imm16(s_imm16),
        .out_imm26(s_imm26), .out_imm_ext(s_imm_ext), .out_pc(s_pc),
        .out_br_target(s_br_target), .out_j_target(s_j_target), .dec_count(s_dec_count)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    function automatic exp_t model(input logic [31:0] inst, input logic [31:0] pc);
        exp_t        e;
        logic [31:0] imm = inst & 32'h0000_FFFF;
        logic [31:0] op  = inst >> 26;
        e.inst   = inst;
        e.pc     = pc;
        e.imm_sx = (imm >= 32'h8000) ? (imm | 32'hFFFF_0000) : imm;
        e.imm_zx = (op >= 12 && op <= 14) ? imm : e.imm_sx;
        e.br     = pc + 32'd4 + e.imm_sx * 4;
        e.jt     = ((pc + 32'd4) & 32'hF000_0000) | ((inst & 32'h03FF_FFFF) * 4);
        return e;
    endfunction

    // Monitor: compare current outputs with the model, then advance the model to the next edge.
    always @(negedge clk) begin
        bit acc;
        if (rst) check("in_ready_rst", in_ready, 1'b0);
        else     check("in_ready", in_ready, q.size() < 2);
        check("out_valid", out_valid, q.size() > 0);
        check("out_valid_sext", s_out_valid, q.size() > 0);
        check("dec_count", dec_count, exp_cnt);
        if (q.size() > 0) begin
            check("opcode", out_opcode, (q[0].inst >> 26) & 32'h3F);
            check("rs", out_rs, (q[0].inst >> 21) & 32'h1F);
            check("rt", out_rt, (q[0].inst >> 16) & 32'h1F);
            check("rd", out_rd, (q[0].inst >> 11) & 32'h1F);
            check("shamt", out_shamt, (q[0].inst >> 6) & 32'h1F);
            check("funct", out_funct, q[0].inst & 32'h3F);
            check("imm16", out_imm16, q[0].inst & 32'hFFFF);
            check("imm26", out_imm26, q[0].inst & 32'h03FF_FFFF);
            check("imm_ext", out_imm_ext, q[0].imm_zx);
            check("imm_ext_sext", s_imm_ext, q[0].imm_sx);
            check("pc", out_pc, q[0].pc);
            check("br_target", out_br_target, q[0].br);
            check("j_target", out_j_target, q[0].jt);
        end else if (exp_zero) begin
            check("zero_imm26", out_imm26, 0);
            check("zero_imm_ext", out_imm_ext, 0);
            check("zero_pc", out_pc, 0);
            check("zero_br", out_br_target, 0);
            check("zero_jt", out_j_target, 0);
        end

        if (rst) begin
            q.delete();
            exp_cnt  = '0;
            exp_zero = 1'b1;
        end else if (flush) begin
            q.delete();
        end else begin
            acc = in_valid && (q.size() < 2);
            if (q.size() > 0 && out_ready) begin
                void'(q.pop_front());
                exp_cnt++;
            end
            if (acc) begin
                q.push_back(model(in_inst, in_pc));
                exp_zero = 1'b0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic load(input logic [31:0] inst, input logic [31:0] pc);
        in_valid = 1'b1;
        in_inst  = inst;
        in_pc    = pc;
    endtask

    initial begin
        repeat (2) tick();
        rst = 1'b0;

        // Sign-extend path
        load(32'h2008_FFFF, 32'h0040_0000);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("t1_valid", out_valid, 1);
        check("t1_opcode", out_opcode, 6'h08);
        check("t1_rs", out_rs, 0);
        check("t1_rt", out_rt, 8);
        check("t1_imm_ext", out_imm_ext, 32'hFFFF_FFFF);
        check("t1_br", out_br_target, 32'h0040_0000);
        drain();

        // Logical zero-extend vs forced sign-extend
        load(32'h3508_FFFF, 32'h0040_0004);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("t2_opcode", out_opcode, 6'h0D);
        check("t2_imm_zext", out_imm_ext, 32'h0000_FFFF);
        check("t2_imm_sext", s_imm_ext, 32'hFFFF_FFFF);
        drain();

        // Jump target
        load(32'h0810_0004, 32'h0040_0010);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        check("t3_opcode", out_opcode, 6'h02);
        check("t3_imm26", out_imm26, 26'h010_0004);
        check("t3_jt", out_j_target, 32'h0040_0010);
        drain();

        // Back-pressure: A in M, B in S, C held upstream
        pulse_reset();
        load(32'h2001_1111, 32'h0000_1000);
        tick();
        load(32'h2002_2222, 32'h0000_1004);
        tick();
        load(32'h2003_3333, 32'h0000_1008);
        @(negedge clk);
        check("bp_in_ready_low", in_ready, 0);
        check("bp_hold_a", out_imm16, 16'h1111);
        tick();
        tick();
        @(negedge clk);
        check("bp_still_low", in_ready, 0);
        check("bp_stable_a", out_imm16, 16'h1111);
        out_ready = 1'b1;
        tick();
        @(negedge clk);
        check("bp_in_ready_high", in_ready, 1);
        check("bp_b_next", out_imm16, 16'h2222);
        tick();
        in_valid = 1'b0;
        tick();
        out_ready = 1'b0;
        @(negedge clk);
        check("bp_count3", dec_count, 3);
        check("bp_empty", out_valid, 0);

        // Flush with M and S full and an input offered
        load(32'h2004_4444, 32'h0000_2000);
        tick();
        load(32'h2005_5555, 32'h0000_2004);
        tick();
        load(32'h2006_6666, 32'h0000_2008);
        flush = 1'b1;
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check("fl_valid", out_valid, 0);
        check("fl_in_ready", in_ready, 1);
        check("fl_count", dec_count, 3);

        // Counter wrap, then reset with M full
        pulse_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            load($urandom, $urandom & 32'hFFFF_FFFC);
            tick();
        end
        in_valid = 1'b0;
        tick();
        @(negedge clk);
        check("wrap_count", dec_count, 1);
        out_ready = 1'b0;
        load(32'h2007_7777, 32'h0000_3000);
        tick();
        in_valid = 1'b0;
        rst      = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst_valid", out_valid, 0);
        check("rst_count", dec_count, 0);
        check("rst_imm_ext", out_imm_ext, 0);
        check("rst_pc", out_pc, 0);
        check("rst_in_ready_after", in_ready, 1);

        // Randomized traffic with occasional flush and reset
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom % 4) != 0;
            out_ready = ($urandom % 3) != 0;
            flush     = ($urandom % 40) == 0;
            rst       = ($urandom % 200) == 0;
            in_inst   = $urandom;
            if ($urandom % 4 == 0)
                in_inst[31:26] = 6'(12 + $urandom_range(0, 2));
            in_pc = $urandom & 32'hFFFF_FFFC;
            tick();
        end
        in_valid  = 1'b0;
        flush     = 1'b0;
        rst       = 1'b0;
        out_ready = 1'b1;
        repeat (4) tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/pipe_decoder.md
# pipe_decoder

Registered, back-pressurable instruction-decode stage that supersedes the purely combinational field splitter. It accepts a 32-bit MIPS instruction word plus its PC over a valid/ready handshake. It emits the split fields, the extended immediate, and the precomputed branch and jump targets from a 2-entry skid buffer. It sits between instruction fetch and register read, supports pipeline flush, and counts decoded instructions for the debug/statistics display.

## Interface
Parameters:
- PC_WIDTH, 32, PC/target width; legal range 28..32.
- ZEXT_LOGIC, 1, 1 = zero-extend imm16 for andi/ori/xori (opcodes 0x0C/0x0D/0x0E); 0 = sign-extend for every opcode.
- CNT_WIDTH, 32, width of dec_count.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream instruction valid.
- in_ready  out  1  stage can accept.
- in_inst  in  32  instruction word.
- in_pc  in  PC_WIDTH  address of in_inst.
- flush  in  1  discard all buffered instructions.
- out_valid  out  1  decoded entry valid.
- out_ready  in  1  downstream accepts.
- out_opcode/out_rs/out_rt/out_rd/out_shamt/out_funct  out  6/5/5/5/5/6  inst[31:26]/[25:21]/[20:16]/[15:11]/[10:6]/[5:0].
- out_imm16  out  16  inst[15:0].
- out_imm26  out  26  inst[25:0].
- out_imm_ext  out  32  extended imm16.
- out_pc  out  PC_WIDTH  PC of the entry.
- out_br_target  out  PC_WIDTH  pc+4+(sext(imm16)<<2).
- out_j_target  out  PC_WIDTH  {(pc+4)[PC_WIDTH-1:28], imm26, 2'b00}.
- dec_count  out  CNT_WIDTH  completed output handshakes.

## Operation
- All decode and target arithmetic is done combinationally on in_inst/in_pc. The result is stored as one entry; outputs are driven only from registers.
- Storage: main register M (drives outputs) and skid register S, each with a valid bit. out_valid = M.valid; in_ready = !S.valid && !rst.
- Accept = in_valid && in_ready. Fire = out_valid && out_ready.
- When S is empty:
  - If accept and (M empty or fire): M <= new.
  - If accept and M is full with no fire: S <= new.
  - If fire with no accept: M.valid <= 0.
- When S is full (in_ready = 0):
  - On fire: M <= S and S.valid <= 0.
- Order is strictly FIFO; no entry is duplicated or lost.
- Arithmetic: target sums are computed modulo 2^PC_WIDTH with carries discarded. The jump high bits come from pc+4, not pc.
- flush (priority over everything):
  - Next cycle M.valid = S.valid = 0.
  - An input accepted in the flush cycle is dropped.
  - A fire in the flush cycle does not count.
- dec_count += 1 on each fire without flush; wraps modulo 2^CNT_WIDTH.
- While out_valid && !out_ready, all out_* fields hold stable.

## Timing
- Reset (rst high at a clock edge):
  - out_valid = 0, all out_* data = 0, dec_count = 0.
  - in_ready = 0 while rst is high and 1 in the first cycle after.
  - Reset mid-stream discards M and S.
- Latency: an instruction accepted at edge N, with the stage empty, is presented with out_valid = 1 after edge N.
- Throughput: 1 instruction/cycle with out_ready held high; in_ready stays 1.
- in_ready depends only on registered state, with no combinational path from out_ready. It falls the cycle after S fills and rises the cycle after S drains.
- Simultaneous accept + fire with M full and S empty: M takes the new entry, S stays empty.

## Test plan
- Sign-extend path: inst 0x2008FFFF at pc 0x00400000 -> opcode 0x08, rs 0, rt 8, imm_ext 0xFFFFFFFF, br_target 0x00400000, out_valid one cycle after accept.
- Logical zero-extend: inst 0x3508FFFF -> opcode 0x0D, imm_ext 0x0000FFFF with ZEXT_LOGIC=1, and 0xFFFFFFFF with ZEXT_LOGIC=0.
- Jump target: inst 0x08100004 at pc 0x00400010 -> opcode 0x02, imm26 0x0100004, j_target 0x00400010.
- Back-pressure: out_ready=0, push A,B,C back-to-back.
  - A is held in M, B goes to S, in_ready drops, C is held upstream.
  - After releasing out_ready, A,B,C emerge in order with fields stable while stalled, and dec_count = 3.
- Flush with M and S full plus an in_valid in the same cycle -> next cycle out_valid 0, in_ready 1, nothing accepted, dec_count unchanged.
- Counter wrap and reset: CNT_WIDTH=4, 17 fires -> dec_count 1.
  - Then assert rst with M full -> next cycle out_valid 0, dec_count 0, outputs 0.
